cdp_mul_layer_ctrl: RTL and testbench

- Per-layer sequencer for the CDP multiplier stage (interpolator × sync-data pair multiply, optional bypass).
- Latches mul-bypass mode safely at layer start and gates input acceptance until exactly the programmed beat count has entered.
- Drains the stage until every beat has left, then pulses done; also flags protocol errors.
- Sits between the CDP register file and the multiplier datapath wrapper.

---
 rtl/cdp_mul_ctrl_pkg.sv | 14 +
 rtl/cdp_mul_layer_ctrl_if.sv | 35 +++
 rtl/cdp_sat_cnt.sv | 30 +++
 rtl/cdp_mul_layer_ctrl.sv | 110 +++++++++++
 tb/tb_cdp_mul_layer_ctrl.sv | 255 +++++++++++++++++++++++++
 5 files changed

// File: rtl/cdp_mul_ctrl_pkg.sv
// Shared types and defaults for the CDP multiplier layer sequencer.
package cdp_mul_ctrl_pkg;

    localparam int CDP_CNT_W = 32;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_RUN   = 3'd2,
        ST_DRAIN = 3'd3,
        ST_DONE  = 3'd4
    } cdp_mul_state_e;

endpackage

// File: rtl/cdp_mul_layer_ctrl_if.sv
// Register-file / datapath side signals of the CDP multiplier layer sequencer.
interface cdp_mul_layer_ctrl_if
    import cdp_mul_ctrl_pkg::*;
#(
    parameter int CNT_W = CDP_CNT_W
);
    logic             reg2dp_op_en;
    logic             reg2dp_mul_bypass;
    logic [CNT_W-1:0] reg2dp_beat_cnt;
    logic             mul_in_fire;
    logic             mul_out_pvld;
    logic             mul_out_prdy;
    logic             ctrl2mul_bypass;
    logic             ctrl2mul_in_en;
    logic             dp2reg_busy;
    logic             dp2reg_done;
    logic             dp2reg_err;
    logic [CNT_W-1:0] dp2reg_stall_cnt;

    // master: register file + datapath environment; slave: the sequencer
    modport master (
        output reg2dp_op_en, reg2dp_mul_bypass, reg2dp_beat_cnt,
        output mul_in_fire, mul_out_pvld, mul_out_prdy,
        input  ctrl2mul_bypass, ctrl2mul_in_en,
        input  dp2reg_busy, dp2reg_done, dp2reg_err, dp2reg_stall_cnt
    );

    modport slave (
        input  reg2dp_op_en, reg2dp_mul_bypass, reg2dp_beat_cnt,
        input  mul_in_fire, mul_out_pvld, mul_out_prdy,
        output ctrl2mul_bypass, ctrl2mul_in_en,
        output dp2reg_busy, dp2reg_done, dp2reg_err, dp2reg_stall_cnt
    );

endinterface

// File: rtl/cdp_sat_cnt.sv
// Clearable up-counter that sticks at all-ones instead of wrapping.
module cdp_sat_cnt
    import cdp_mul_ctrl_pkg::*;
#(
    parameter int CNT_W = CDP_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             inc,
    output logic [CNT_W-1:0] cnt
);
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr)
            cnt_d = '0;
        else if (inc && (cnt_q != '1))
            cnt_d = cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/cdp_mul_layer_ctrl.sv
// Per-layer sequencer for the CDP multiplier stage: latch mode, gate beats in, drain, pulse done.
// Optional output-stall counter enabled by defining CDP_MUL_CTRL_PERF_EN.
module cdp_mul_layer_ctrl
    import cdp_mul_ctrl_pkg::*;
#(
    parameter int CNT_W = CDP_CNT_W
) (
    input  logic                 nvdla_core_clk,
    input  logic                 nvdla_core_rst,
    cdp_mul_layer_ctrl_if.slave  io
);
    cdp_mul_state_e   state_q, state_d;
    logic [CNT_W-1:0] beats_q, beats_d;
    logic             bypass_q, bypass_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             err_q, err_d;
    logic [CNT_W-1:0] in_cnt, out_cnt;
    logic             out_fire, in_en, cnt_act, load;
    logic             in_inc, out_inc, in_last, out_last, overrun;

    always_comb begin
        out_fire = io.mul_out_pvld & io.mul_out_prdy;
        in_en    = (state_q == ST_RUN);
        cnt_act  = in_en | (state_q == ST_DRAIN);
        load     = (state_q == ST_LOAD);
        in_inc   = in_en & io.mul_in_fire;
        out_inc  = cnt_act & out_fire;
        in_last  = in_inc & (in_cnt == beats_q);
        out_last = out_inc & (out_cnt == beats_q);
        // one bit wider so the comparison holds even next to all-ones
        overrun  = out_inc & (({1'b0, out_cnt} + {{CNT_W{1'b0}}, 1'b1}) >
                              ({1'b0, in_cnt} + {{CNT_W{1'b0}}, in_inc}));

        state_d  = state_q;
        beats_d  = beats_q;
        bypass_d = bypass_q;
        case (state_q)
            ST_IDLE:  if (io.reg2dp_op_en) state_d = ST_LOAD;
            ST_LOAD: begin
                beats_d  = io.reg2dp_beat_cnt;
                bypass_d = io.reg2dp_mul_bypass;
                state_d  = ST_RUN;
            end
            ST_RUN:   if (in_last) state_d = out_last ? ST_DONE : ST_DRAIN;
            ST_DRAIN: if (out_last) state_d = ST_DONE;
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase

        busy_d = (state_d != ST_IDLE);
        done_d = (state_d == ST_DONE);
        err_d  = err_q
               | (io.reg2dp_op_en & (state_q != ST_IDLE))
               | (io.mul_in_fire & ~in_en)
               | (out_fire & ~cnt_act)
               | overrun;
    end

    always_ff @(posedge nvdla_core_clk or posedge nvdla_core_rst) begin
        if (nvdla_core_rst) begin
            state_q  <= ST_IDLE;
            beats_q  <= '0;
            bypass_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            beats_q  <= beats_d;
            bypass_q <= bypass_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            err_q    <= err_d;
        end
    end

    cdp_sat_cnt #(.CNT_W(CNT_W)) u_in_cnt (
        .clk (nvdla_core_clk), .rst (nvdla_core_rst),
        .clr (load), .inc (in_inc), .cnt (in_cnt)
    );

    cdp_sat_cnt #(.CNT_W(CNT_W)) u_out_cnt (
        .clk (nvdla_core_clk), .rst (nvdla_core_rst),
        .clr (load), .inc (out_inc), .cnt (out_cnt)
    );

`ifdef CDP_MUL_CTRL_PERF_EN
    logic             stall_inc;
    logic [CNT_W-1:0] stall_cnt;

    assign stall_inc = cnt_act & io.mul_out_pvld & ~io.mul_out_prdy;

    cdp_sat_cnt #(.CNT_W(CNT_W)) u_stall_cnt (
        .clk (nvdla_core_clk), .rst (nvdla_core_rst),
        .clr (load), .inc (stall_inc), .cnt (stall_cnt)
    );

    assign io.dp2reg_stall_cnt = stall_cnt;
`else
    assign io.dp2reg_stall_cnt = '0;
`endif

    assign io.ctrl2mul_bypass = bypass_q;
    assign io.ctrl2mul_in_en  = in_en;
    assign io.dp2reg_busy     = busy_q;
    assign io.dp2reg_done     = done_q;
    assign io.dp2reg_err      = err_q;

endmodule

// File: tb/tb_cdp_mul_layer_ctrl.sv
// Directed + randomized bench for cdp_mul_layer_ctrl against a beat-counting reference model.
module tb_cdp_mul_layer_ctrl;
    import cdp_mul_ctrl_pkg::*;

    localparam int CNT_W = 32;
`ifdef CDP_MUL_CTRL_PERF_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    cdp_mul_layer_ctrl_if #(.CNT_W(CNT_W)) io();
    cdp_mul_layer_ctrl #(.CNT_W(CNT_W)) dut (
        .nvdla_core_clk (clk),
        .nvdla_core_rst (rst),
        .io             (io)
    );

    int n_chk = 0, n_pass = 0, n_fail = 0;
    int cyc = 0;

    // stimulus knobs
    bit               k_rst = 1'b1, k_op, k_byp, k_rand_reg;
    bit               k_in_force, k_out_force, k_rdy_force0;
    logic [CNT_W-1:0] k_beat;
    int               k_in_pct = 100, k_rdy_pct = 100;

    // emulated 2-cycle datapath: entry cycle of each accepted beat
    int dpq[$];

    // reference model: what the layer should look like, in beats and cycles
    bit     m_busy, m_byp, m_err, m_done;
    int     m_age;
    longint m_ins, m_outs, m_n, m_stall;

    int obs_inen, obs_done, done_cyc;

    function automatic bit m_in_en();
        return m_busy && (m_age >= 1) && (m_ins < m_n);
    endfunction

    function automatic void model_reset();
        m_busy = 0; m_byp = 0; m_err = 0; m_done = 0;
        m_age = 0; m_ins = 0; m_outs = 0; m_n = 0; m_stall = 0;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: got %0h want %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic step();
        bit ien, run, fin, pv, pr, of, op, byp, fi;
        logic [CNT_W-1:0] beat;
        longint nins, nouts;
        @(negedge clk);
        chk("busy",      io.dp2reg_busy,      m_busy);
        chk("in_en",     io.ctrl2mul_in_en,   m_in_en());
        chk("done",      io.dp2reg_done,      m_done);
        chk("err",       io.dp2reg_err,       m_err);
        chk("bypass",    io.ctrl2mul_bypass,  m_byp);
        chk("stall_cnt", io.dp2reg_stall_cnt, PERF ? m_stall : 64'd0);
        if (io.ctrl2mul_in_en === 1'b1) obs_inen++;
        if (io.dp2reg_done === 1'b1) begin obs_done++; done_cyc = cyc; end

        rst  = k_rst;
        ien  = m_in_en();
        op   = k_op;
        byp  = k_rand_reg ? 1'($urandom_range(0, 1)) : k_byp;
        beat = k_rand_reg ? CNT_W'($urandom_range(0, 12)) : k_beat;
        fi   = k_in_force || (ien && ($urandom_range(0, 99) < k_in_pct));
        pv   = k_out_force || (dpq.size() > 0 && dpq[0] <= cyc - 2);
        pr   = !k_rdy_force0 && ($urandom_range(0, 99) < k_rdy_pct);
        io.reg2dp_op_en      = op;
        io.reg2dp_mul_bypass = byp;
        io.reg2dp_beat_cnt   = beat;
        io.mul_in_fire       = fi;
        io.mul_out_pvld      = pv;
        io.mul_out_prdy      = pr;

        of = pv && pr;
        if (of && !k_out_force) void'(dpq.pop_front());
        if (fi && ien && !k_out_force) dpq.push_back(cyc);

        if (k_rst) begin
            model_reset();
            dpq.delete();
        end else begin
            run = m_busy && (m_age >= 1) && !m_done;
            if (op && m_busy) m_err = 1;
            if (fi && !ien)   m_err = 1;
            if (of && !run)   m_err = 1;
            nins  = m_ins + ((fi && ien) ? 1 : 0);
            nouts = m_outs;
            if (of && run) begin
                nouts++;
                if (nouts > nins) m_err = 1;
            end
            if (m_busy && m_age == 0) begin
                m_n = longint'(beat) + 1; m_byp = byp; m_stall = 0;
            end else if (run && pv && !pr) m_stall++;
            fin    = run && (nins == m_n) && (nouts == m_n);
            m_ins  = nins;
            m_outs = nouts;
            if (m_done) begin
                m_busy = 0; m_done = 0;
            end else if (m_busy) begin
                m_age++; m_done = fin;
            end else if (op) begin
                m_busy = 1; m_age = 0; m_ins = 0; m_outs = 0;
            end
        end
        cyc++;
    endtask

    // issue op_en for one cycle; returns that cycle index
    task automatic start_layer(input int beat, input bit byp, output int t0);
        obs_inen = 0; obs_done = 0; done_cyc = -1;
        k_beat = CNT_W'(beat); k_byp = byp; k_op = 1;
        t0 = cyc;
        step();
        k_op = 0;
    endtask

    task automatic finish_layer();
        for (int i = 0; i < 400 && m_busy; i++) step();
        chk("layer_timeout", {63'd0, m_busy}, 64'd0);
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 400 && !(m_busy && m_age >= 1 && m_ins == m_n); i++) step();
        chk("drain_timeout", {63'd0, m_ins == m_n}, 64'd1);
    endtask

    initial begin
        int t0;
        model_reset();
        io.reg2dp_op_en = 0; io.reg2dp_mul_bypass = 0; io.reg2dp_beat_cnt = '0;
        io.mul_in_fire = 0; io.mul_out_pvld = 0; io.mul_out_prdy = 0;

        // reset state
        repeat (2) step();
        k_rst = 0;
        repeat (2) step();

        // 4-beat layer, full throughput
        start_layer(3, 0, t0);
        finish_layer();
        chk("A_in_en_cycles", obs_inen, 4);
        chk("A_done_pulses",  obs_done, 1);
        chk("A_latency",      done_cyc - t0, 8);
        chk("A_err",          io.dp2reg_err, 0);
        step();

        // 1-beat layer, last in and last out in the same cycle
        k_in_pct = 0;
        start_layer(0, 1, t0);
        step();
        k_in_force = 1; k_out_force = 1;
        step();
        k_in_force = 0; k_out_force = 0;
        finish_layer();
        chk("B_latency",     done_cyc - t0, 3);
        chk("B_done_pulses", obs_done, 1);
        chk("B_bypass",      io.ctrl2mul_bypass, 1);
        k_in_pct = 100;
        step();

        // 8-beat layer with a 5-cycle output stall in drain
        start_layer(7, 0, t0);
        wait_drain();
        k_rdy_force0 = 1;
        repeat (5) step();
        k_rdy_force0 = 0;
        finish_layer();
        chk("C_latency",   done_cyc - t0, 17);
        chk("C_stall_cnt", io.dp2reg_stall_cnt, PERF ? 64'd5 : 64'd0);
        step();

        // bypass request toggles mid-layer; mode holds until the next LOAD
        start_layer(5, 0, t0);
        repeat (3) step();
        k_byp = 1;
        finish_layer();
        chk("D_bypass_held", io.ctrl2mul_bypass, 0);
        step();
        start_layer(2, 1, t0);
        finish_layer();
        chk("D_bypass_next", io.ctrl2mul_bypass, 1);

        // random layers with register inputs jittering every cycle
        for (int l = 0; l < 6; l++) begin
            k_in_pct  = $urandom_range(30, 100);
            k_rdy_pct = $urandom_range(30, 100);
            k_rand_reg = 1;
            k_op = 1; step(); k_op = 0;
            finish_layer();
            k_rand_reg = 0;
            repeat ($urandom_range(0, 3)) step();
        end
        chk("R_err", io.dp2reg_err, 0);
        k_in_pct = 100; k_rdy_pct = 100;
        step();

        // protocol errors: op_en mid-run, in_fire in drain
        start_layer(3, 0, t0);
        repeat (2) step();
        k_op = 1; step(); k_op = 0;
        wait_drain();
        k_in_force = 1; step(); k_in_force = 0;
        finish_layer();
        chk("E_err",         io.dp2reg_err, 1);
        chk("E_done_pulses", obs_done, 1);
        chk("E_latency",     done_cyc - t0, 8);
        step();

        // asynchronous reset in drain, then a clean layer
        start_layer(7, 0, t0);
        wait_drain();
        step();
        @(posedge clk);
        #2;
        rst = 1; k_rst = 1;
        #1;
        chk("F_rst_busy",   io.dp2reg_busy, 0);
        chk("F_rst_in_en",  io.ctrl2mul_in_en, 0);
        chk("F_rst_done",   io.dp2reg_done, 0);
        chk("F_rst_err",    io.dp2reg_err, 0);
        chk("F_rst_bypass", io.ctrl2mul_bypass, 0);
        chk("F_rst_stall",  io.dp2reg_stall_cnt, 0);
        model_reset();
        dpq.delete();
        repeat (2) step();
        k_rst = 0;
        step();
        start_layer(2, 1, t0);
        finish_layer();
        chk("F_done_pulses", obs_done, 1);
        chk("F_latency",     done_cyc - t0, 7);
        chk("F_err",         io.dp2reg_err, 0);
        step();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
